// File: rtl/cs_adder_pkg.sv
// Shared types and elaboration helpers for the carry-save final adder.
package cs_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_LPS   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Pipeline stage count N = ceil(L / levels_per_stage).
  function automatic int num_stages(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/cs_final_adder_prefix_gp_cell.sv
// Generic Kogge-Stone prefix node: merges a high (G,P) group with the adjacent low group.
module prefix_gp_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/cs_final_adder.sv
// Pipelined Kogge-Stone carry-propagate adder resolving a carry-save pair, valid/ready on both sides.
// Optional subtract mode (in_sub port) enabled by defining CS_FINAL_ADDER_SUB_EN.
module cs_final_adder
  import cs_adder_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int LEVELS_PER_STAGE = DEF_LPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef CS_FINAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int L  = clog2(WIDTH);
  localparam int N  = num_stages(WIDTH, LEVELS_PER_STAGE);
  localparam int NM = (N > 1) ? N - 1 : 1;

  logic [N:0]       v_q, v_d, adv;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
`ifdef CS_FINAL_ADDER_SUB_EN
  logic             sub_q, sub_d;
`endif

  gp_t  [WIDTH-1:0] rgp_q [0:NM-1];
  gp_t  [WIDTH-1:0] rgp_d [0:NM-1];
  logic [WIDTH-1:0] rpo_q [0:NM-1];
  logic [WIDTH-1:0] rpo_d [0:NM-1];
  logic             rcin_q [0:NM-1];
  logic             rcin_d [0:NM-1];
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_eff, p0, g_fin, sum_nxt;
  logic             cin_eff, cout_nxt;
  gp_t  [WIDTH-1:0] gp0;
  gp_t  [WIDTH-1:0] lv_in  [0:N-1];
  gp_t  [WIDTH-1:0] lv_out [0:N-1];
  logic [WIDTH-1:0] po_in  [0:N-1];
  logic             cin_in [0:N-1];

  // Handshake: a register may load when it, or everything downstream of it, can drain.
  always_comb begin
    logic full;
    full = 1'b1;
    for (int k = N; k >= 0; k--) begin
      full   = full & v_q[k];
      adv[k] = ~full | out_ready;
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = v_q[N];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  always_comb begin
    v_d = v_q;
    if (adv[0]) v_d[0] = in_valid;
    for (int k = 1; k <= N; k++) begin
      if (adv[k]) v_d[k] = v_q[k-1];
    end
  end

  // R0 -> stage 0: bitwise generate/propagate; cin folded into bit 0 as g[-1].
  always_comb begin
    b_eff   = b_q;
    cin_eff = cin_q;
`ifdef CS_FINAL_ADDER_SUB_EN
    if (sub_q) begin
      b_eff   = ~b_q;
      cin_eff = 1'b1;
    end
`endif
    p0 = a_q ^ b_eff;
    for (int i = 0; i < WIDTH; i++) begin
      gp0[i].g = a_q[i] & b_eff[i];
      gp0[i].p = p0[i];
    end
    gp0[0].g = gp0[0].g | (p0[0] & cin_eff);
  end

  always_comb begin
    lv_in[0]  = gp0;
    po_in[0]  = p0;
    cin_in[0] = cin_eff;
    for (int k = 1; k < N; k++) begin
      lv_in[k]  = rgp_q[k-1];
      po_in[k]  = rpo_q[k-1];
      cin_in[k] = rcin_q[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int J0 = k * LEVELS_PER_STAGE;
    localparam int NL = (L - J0 < LEVELS_PER_STAGE) ? (L - J0) : LEVELS_PER_STAGE;
    gp_t [WIDTH-1:0] lv [0:NL];

    assign lv[0] = lv_in[k];
    for (genvar i = 0; i < NL; i++) begin : g_level
      localparam int D = 1 << (J0 + i);
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        if (b >= D) begin : g_node
          prefix_gp_cell u_cell (
            .gh (lv[i][b].g),
            .ph (lv[i][b].p),
            .gl (lv[i][b-D].g),
            .pl (lv[i][b-D].p),
            .g  (lv[i+1][b].g),
            .p  (lv[i+1][b].p)
          );
        end else begin : g_pass
          assign lv[i+1][b] = lv[i][b];
        end
      end
    end
    assign lv_out[k] = lv[NL];
  end

  // Last stage -> RN: carry into bit i is the group generate of bits i-1..0.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) g_fin[i] = lv_out[N-1][i].g;
    sum_nxt  = po_in[N-1] ^ {g_fin[WIDTH-2:0], cin_in[N-1]};
    cout_nxt = g_fin[WIDTH-1];
  end

  always_comb begin
    a_d   = adv[0] ? in_a   : a_q;
    b_d   = adv[0] ? in_b   : b_q;
    cin_d = adv[0] ? in_cin : cin_q;
`ifdef CS_FINAL_ADDER_SUB_EN
    sub_d = adv[0] ? in_sub : sub_q;
`endif
    for (int k = 0; k < NM; k++) begin
      rgp_d[k]  = rgp_q[k];
      rpo_d[k]  = rpo_q[k];
      rcin_d[k] = rcin_q[k];
    end
    for (int k = 0; k < N - 1; k++) begin
      if (adv[k+1]) begin
        rgp_d[k]  = lv_out[k];
        rpo_d[k]  = po_in[k];
        rcin_d[k] = cin_in[k];
      end
    end
    sum_d  = adv[N] ? sum_nxt  : sum_q;
    cout_d = adv[N] ? cout_nxt : cout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
`ifdef CS_FINAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
      for (int k = 0; k < NM; k++) begin
        rgp_q[k]  <= '0;
        rpo_q[k]  <= '0;
        rcin_q[k] <= 1'b0;
      end
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cin_q  <= cin_d;
`ifdef CS_FINAL_ADDER_SUB_EN
      sub_q  <= sub_d;
`endif
      for (int k = 0; k < NM; k++) begin
        rgp_q[k]  <= rgp_d[k];
        rpo_q[k]  <= rpo_d[k];
        rcin_q[k] <= rcin_d[k];
      end
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_cs_final_adder.sv
// Directed bench for cs_final_adder: vector table, streaming, backpressure and reset sequences.
module tb_cs_final_adder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b1;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CS_FINAL_ADDER_SUB_EN
  logic         in_sub = 1'b0;
`endif

  cs_final_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef CS_FINAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int outs  = 0;
  logic [W:0] exp_q [$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Output monitor: every transfer is matched against the expected-result queue.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && out_valid && out_ready) begin
      outs++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h required no output", {out_cout, out_sum});
      end else begin
        check("result", {out_cout, out_sum}, exp_q.pop_front());
      end
    end
  end

  // Starts and ends just after a falling edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W:0] e, output int waited);
    waited = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    forever begin
      #4;
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        check("send_timeout", {{W{1'b0}}, in_ready}, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_timed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W:0] e);
    int w;
    int cnt;
    cnt = 0;
    send(a, b, c, e, w);
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({nm, "_latency"}, cnt, 3);
    check({nm, "_value"}, {out_cout, out_sum}, e);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int w, waits, o0, acc;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] first_exp;

    tbl[0]  = '{{W{1'b1}}, '0, 1'b1, '0, 1'b1};
    tbl[1]  = '{'0, '0, 1'b0, '0, 1'b0};
    tbl[2]  = '{{W{1'b1}}, {W{1'b1}}, 1'b1, {W{1'b1}}, 1'b1};
    tbl[3]  = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, {W{1'b1}}, 1'b0};
    tbl[4]  = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, '0, 1'b1};
    tbl[5]  = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0};
    tbl[6]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, '0, 1'b1};
    tbl[7]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
    tbl[8]  = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, '0, 1'b1};
    tbl[9]  = '{64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
    tbl[10] = '{'0, '0, 1'b1, 64'd1, 1'b0};

    // Reset held two edges with in_valid asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {{W{1'b0}}, in_ready}, 0);
    check("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("rst_out_sum", {1'b0, out_sum}, 0);
    check("rst_out_cout", {{W{1'b0}}, out_cout}, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", {{W{1'b0}}, in_ready}, 1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      send_timed($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, {tbl[i].co, tbl[i].s});
    end

`ifdef CS_FINAL_ADDER_SUB_EN
    in_sub = 1'b1;
    send_timed("sub_5_7", 64'd5, 64'd7, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send_timed("sub_7_5", 64'd7, 64'd5, 1'b0, {1'b1, 64'd2});
    in_sub = 1'b0;
`endif

    // Streaming at full rate.
    waits = 0;
    o0 = outs;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc), w);
      waits += w;
    end
    check("stream_ready_stalls", waits, 0);
    drain(20);
    check("stream_count", outs - o0, 1000);

    // Backpressure: out_ready low for ten cycles with a continuous offer.
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    o0 = outs;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_a = 64'h1000 + 64'(acc);
      in_b = 64'(acc) << 60;
      in_cin = 1'b1;
      in_valid = 1'b1;
      #4;
      if (in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin));
        acc++;
      end
      @(negedge clk);
    end
    check("bp_accepted", acc, 4);
    check("bp_ready_low", {{W{1'b0}}, in_ready}, 0);
    check("bp_out_valid", {{W{1'b0}}, out_valid}, 1);
    first_exp = model(64'h1000, '0, 1'b1);
    check("bp_hold_value", {out_cout, out_sum}, first_exp);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    check("bp_count", outs - o0, 4);

    // Reset with three beats in flight.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send(64'hDEAD_0000 + 64'(i), 64'd3, 1'b0, model(64'hDEAD_0000 + 64'(i), 64'd3, 1'b0), w);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_in_ready", {{W{1'b0}}, in_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    o0 = outs;
    for (int i = 0; i < 6; i++) begin
      check("mid_rst_no_valid", {{W{1'b0}}, out_valid}, 0);
      @(negedge clk);
    end
    check("mid_rst_no_emit", outs - o0, 0);
    send_timed("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, {1'b1, 64'd1});
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cs_final_adder.md
# cs_final_adder

Pipelined carry-propagate adder that consumes the redundant carry-save pair (sum vector, carry vector) produced by the full/half-adder compressor tree and resolves it into a binary result. It sits directly downstream of the compressor-tree stage in the generated multiplier datapath and feeds the product register. It uses a Kogge-Stone parallel-prefix network built from generic g/p cells, with pipeline registers every LEVELS_PER_STAGE prefix levels and a valid/ready handshake on both sides.

## Interface
- WIDTH, 64: operand width; must be a power of two, at least 4. L = log2(WIDTH) prefix levels.
- LEVELS_PER_STAGE, 2: prefix levels per pipeline stage, 1..L. N = ceil(L / LEVELS_PER_STAGE).

- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  carry-save sum vector.
- in_b  in  WIDTH  carry-save carry vector, already aligned by the tree.
- in_cin  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
- out_cout  out  1  carry-out of the WIDTH-bit add.

## Operation
- Register chain R0..RN:
  - R0 captures in_a, in_b, in_cin.
  - Between R0 and R1: bitwise g = a&b and p = a^b, with cin injected as g[-1], then the first LEVELS_PER_STAGE prefix levels.
  - Each following stage evaluates the next LEVELS_PER_STAGE levels.
  - The last stage also forms the sum as p XOR the carries shifted by one position. RN drives out_sum and out_cout.
- Every stage k carries the original p vector alongside the (G,P) group vector.
- Each stage has a valid bit v_k. Stage k advances when !v_k or stage k+1 advances. Stage N advances when !v_N or out_ready.
- in_ready equals the advance condition of stage 0. It is a combinational ready chain with no skid buffer.
- Transfers occur when valid&ready on a rising edge. The upstream stage holds in_valid and its data stable until the transfer.
- Throughput is one beat per cycle when out_ready=1. Bubbles collapse: an empty stage always accepts.
- Capacity is N+1 beats. Results leave in order. No beat is dropped or duplicated.
- out_sum and out_cout stay stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0 at a rising edge):
  - All v_k and all data registers clear to 0, so out_valid=0, out_sum=0 and out_cout=0.
  - While rst_n=0, in_ready=0 and inputs are ignored.
  - Reset mid-stream discards all beats in flight. Nothing is emitted for them.
- Arithmetic is unsigned modulo 2^WIDTH. out_cout is bit WIDTH of the full sum.

## Timing
- A beat accepted at edge t appears with out_valid=1 after edge t+N, provided no stall occurs. Default N=3.
- Each stall cycle at the output adds one cycle for every beat queued behind it.
- Longest combinational path is LEVELS_PER_STAGE prefix cells plus the ready chain of N+1 AND/OR terms.
- After rst_n rises, in_ready=1 in the first cycle.

## Configuration
- CS_FINAL_ADDER_SUB_EN defined:
  - Adds port in_sub (in, 1), captured into R0 with the operands.
  - When in_sub=1, in_b is bitwise inverted and the effective carry-in is forced to 1, giving in_a - in_b mod 2^WIDTH.
  - out_cout=1 means no borrow.
- CS_FINAL_ADDER_SUB_EN undefined: in_sub does not exist and in_cin is used directly.

## Structure
- Shared package cs_adder_pkg holds:
  - localparam helpers clog2 and the stage count N.
  - a typedef for the packed (G,P) pair.
- One sub-module, prefix_gp_cell, computes G = Gh | (Ph & Gl) and P = Ph & Pl. It is instantiated per prefix node.
- Levels are generated by generate loops. A pipeline register is inserted after level j when (j+1) mod LEVELS_PER_STAGE = 0 or j = L-1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_sum=0, out_cout=0. The first cycle after release shows in_ready=1.
- Single beat, default parameters: in_a=all ones, in_b=0, in_cin=1 -> out_sum=0, out_cout=1, with out_valid rising exactly 3 edges after acceptance.
- Streaming: 1000 random beats with out_ready=1 -> one result per cycle, in order, each equal to a+b+cin, with in_ready never low.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> exactly 4 beats accepted and in_ready low thereafter. Releasing out_ready yields all beats in order, no duplicates.
- Reset mid-stream: 3 beats in flight, then rst_n=0 for one edge -> out_valid stays 0 and the old beats are never emitted. A new beat completes with normal latency.
- CS_FINAL_ADDER_SUB_EN defined:
  - a=5, b=7, sub=1 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0.
  - a=7, b=5, sub=1 -> out_sum=2, out_cout=1.
